decim_sched: RTL and testbench
==============================

# decim_sched

Round-robin scheduler that shares one decimation stage among `NUM_CH` input streams. Each channel gets its own decimation phase counter. One sample per cycle is granted, and for each channel only every `factor`-th sample is forwarded to a single registered output with a channel tag. The block sits between the per-channel front-end sample sources and the shared downstream filter/packetizer. It also owns the runtime reconfiguration of the decimation factor.

## Interface
Parameters:
- `NUM_CH`, default 4: number of input channels, 2..16.
- `WIDTH`, default 16: signed sample width.
- `MAX_FACTOR`, default 16: largest legal decimation factor.
- `DEFAULT_FACTOR`, default 4: factor loaded at reset.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: scheduler enable. When low, no grants are issued; pending output still drains.
- `cfg_load`, in, 1: request to load `cfg_factor`. Single-cycle pulse.
- `cfg_factor`, in, FW=$clog2(MAX_FACTOR)+1: new factor.
- `cfg_busy`, out, 1: reconfiguration in progress.
- `ch_valid`, in, NUM_CH: per-channel sample valid.
- `ch_data`, in, NUM_CH×WIDTH: per-channel signed samples, packed, channel 0 in the LSBs.
- `ch_ready`, out, NUM_CH: per-channel accept, one-hot or zero.
- `out_valid`, out, 1: output sample valid.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, WIDTH: kept sample.
- `out_ch`, out, CW=$clog2(NUM_CH): source channel of `out_data`.

## Operation
- **States.** The FSM has two states, RUN and DRAIN. Reset enters RUN.
- **RUN.**
  - If `en` is high, the arbiter picks the first channel with `ch_valid` high, searching from `rr_ptr` upward with wrap-around.
  - `keep` = (`phase[g]` == `factor`-1).
  - The transfer is accepted when `keep` is 0, or when the output register is empty, or when `out_ready` is high this cycle.
  - On accept:
    - `ch_ready[g]` is high.
    - `phase[g]` increments, wrapping to 0 after `factor`-1.
    - `rr_ptr` ← g+1 mod NUM_CH.
    - If `keep` is 1, the output register loads `ch_data[g]` and `out_ch` ← g.
  - Dropped samples are consumed: `ch_ready` is asserted and nothing is output.
  - If not accepted, `ch_ready` is all zero and `rr_ptr` is unchanged. The same channel is re-offered the next cycle.
- **Output handshake.** `out_valid` stays high until `out_valid & out_ready`. `out_data` and `out_ch` stay stable while `out_valid` is high and `out_ready` is low. Load and unload in the same cycle is allowed (full throughput).
- **Reconfiguration.**
  - `cfg_load` in RUN latches `cfg_factor` into `pend_factor` and moves to DRAIN. `cfg_busy` = 1.
  - In DRAIN, no grants are issued.
  - When the output register is empty:
    - `factor` ← `pend_factor`, clamped to 1..MAX_FACTOR (0 → 1, >MAX → MAX).
    - All `phase` counters clear.
    - The FSM returns to RUN.
  - `cfg_load` during DRAIN overwrites `pend_factor`.
- **Factor 1.** `factor`=1 keeps every sample.
- **Phase width.** `phase` registers are FW bits wide.

## Timing
- Grant and `ch_ready` are combinational from `ch_valid`, the state, `rr_ptr` and the output-register status. There is no combinational path from `ch_data`.
- `out_valid` rises one cycle after the accepting edge (latency 1).
- DRAIN lasts at least 1 cycle. `cfg_busy` falls in the cycle RUN resumes. The first grant under the new factor is in that cycle.
- Reset values:
  - `out_valid` 0, `out_data` 0, `out_ch` 0, `ch_ready` 0, `cfg_busy` 0.
  - `phase` all 0, `rr_ptr` 0, `factor` DEFAULT_FACTOR, state RUN.
- `rst` mid-operation discards any held output sample and any pending reconfiguration. Reset has priority over all inputs.
- `cfg_load` in the same cycle as an accepted transfer: the transfer completes with the old factor, then the FSM enters DRAIN.
- `en` low in the same cycle as `cfg_load`: DRAIN proceeds normally.

## Configuration
- **`DECIM_SCHED_STATS_EN` defined:**
  - Adds per-channel 16-bit saturating counters of kept samples and of dropped-by-decimation samples.
  - Counters clear on `rst` and on each factor load.
  - Read-out ports are added: input `stat_sel` (CW), outputs `stat_kept` (16) and `stat_drop` (16), both registered with 1-cycle latency.
- **Not defined:** the ports and counters are absent. Core behaviour is identical.

## Structure
- **Shared package `decim_pkg`:**
  - state enum `decim_state_t` {RUN, DRAIN}
  - FW/CW width functions
  - factor clamp function
  - stats counter width constant
- **Sub-module `rr_arbiter`:** parameterised NUM_CH, round-robin priority pick from a request vector and a pointer. Outputs a one-hot grant and a binary index; purely combinational.

## Test plan
- **Single-channel decimation:** NUM_CH=4, factor 4; ch0 sends 1..12 continuously, others idle → out_data 4, 8, 12 with out_ch=0; ch_ready[0] high every cycle.
- **Round-robin fairness:** all 4 channels valid every cycle, factor 1 → out_ch sequence 0, 1, 2, 3, 0… with one output per cycle.
- **Back-pressure:**
  - Factor 2, out_ready held low for 5 cycles → `out_data` stable.
  - A keep-sample is not accepted; its `ch_ready` stays low.
  - Drop-samples are still consumed.
  - On release, no sample is lost or duplicated.
- **Reconfiguration under load:** factor 4 → `cfg_load` with 2 while an output is held → `cfg_busy` stays high until the output drains, then phases clear and the next output is each channel's 2nd post-load sample.
- **Factor clamps:** `cfg_factor` 0 → behaves as 1. `cfg_factor` = MAX_FACTOR+5 → keeps every MAX_FACTOR-th sample.
- **Reset mid-stream:** assert rst with `out_valid` high and in DRAIN → next cycle all outputs 0, factor = DEFAULT_FACTOR, state RUN, arbitration restarts at ch0.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared types and width helpers for the decimation scheduler.
package decim_pkg;
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} decim_state_t;

    localparam int STAT_W = 16;

    function automatic int factor_w(input int max_factor);
        return $clog2(max_factor) + 1;
    endfunction

    function automatic int chan_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int clamp_factor(input int f, input int max_factor);
        if (f < 1) return 1;
        if (f > max_factor) return max_factor;
        return f;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CW-1:0]     idx,
    output logic              any
);
    logic [2*NUM_CH-1:0] rot;
    int sel;
    int pos;

    always_comb begin
        rot   = {req, req} >> ptr;
        sel   = 0;
        any   = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sel = j;
                any = 1'b1;
            end
        end
        pos = int'(ptr) + sel;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        idx   = CW'(pos);
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) grant[i] = any && (idx == CW'(i));
    end
endmodule

// File: rtl/decim_sched.sv
// Round-robin shared decimator with per-channel phase and runtime factor reload.
// Optional per-channel kept/drop statistics when DECIM_SCHED_STATS_EN is defined.
module decim_sched
    import decim_pkg::*;
#(
    parameter int  NUM_CH         = 4,
    parameter int  WIDTH          = 16,
    parameter int  MAX_FACTOR     = 16,
    parameter int  DEFAULT_FACTOR = 4,
    localparam int FW             = factor_w(MAX_FACTOR),
    localparam int CW             = chan_w(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           cfg_load,
    input  logic [FW-1:0]                  cfg_factor,
    output logic                           cfg_busy,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [WIDTH-1:0]        out_data,
    output logic [CW-1:0]                  out_ch
`ifdef DECIM_SCHED_STATS_EN
    ,
    input  logic [CW-1:0]                  stat_sel,
    output logic [STAT_W-1:0]              stat_kept,
    output logic [STAT_W-1:0]              stat_drop
`endif
);
    decim_state_t state, state_nxt;
    logic [FW-1:0] factor, pend_factor;
    logic [NUM_CH-1:0][FW-1:0] phase;
    logic [CW-1:0] rr_ptr, gidx, ptr_nxt;
    logic [NUM_CH-1:0] req, gnt;
    logic any, keep, accept, apply_cfg;

    assign req = (!rst && state == RUN && en) ? ch_valid : '0;

    rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gidx),
        .any   (any)
    );

    // A drop never touches the output register, so only a keep can stall.
    assign keep     = (phase[gidx] == factor - FW'(1));
    assign accept   = any && (!keep || !out_valid || out_ready);
    assign ch_ready = accept ? gnt : '0;
    assign ptr_nxt  = (gidx == CW'(NUM_CH - 1)) ? '0 : gidx + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        apply_cfg = 1'b0;
        cfg_busy  = (state == DRAIN);
        case (state)
            RUN:   if (cfg_load) state_nxt = DRAIN;
            DRAIN: if (!cfg_load && !out_valid) begin
                state_nxt = RUN;
                apply_cfg = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            factor      <= FW'(DEFAULT_FACTOR);
            pend_factor <= FW'(DEFAULT_FACTOR);
            phase       <= '0;
            rr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
        end else begin
            if (cfg_load) pend_factor <= cfg_factor;
            if (apply_cfg) begin
                factor <= FW'(clamp_factor(int'(pend_factor), MAX_FACTOR));
                phase  <= '0;
            end else if (accept) begin
                phase[gidx] <= keep ? '0 : phase[gidx] + FW'(1);
            end
            if (accept) rr_ptr <= ptr_nxt;
            if (accept && keep) begin
                out_valid <= 1'b1;
                out_data  <= $signed(ch_data[gidx]);
                out_ch    <= gidx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DECIM_SCHED_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] kept_cnt, drop_cnt;

    always_ff @(posedge clk) begin
        if (rst || apply_cfg) begin
            kept_cnt <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (keep && kept_cnt[gidx] != '1)  kept_cnt[gidx] <= kept_cnt[gidx] + 1'b1;
            if (!keep && drop_cnt[gidx] != '1) drop_cnt[gidx] <= drop_cnt[gidx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_kept <= '0;
            stat_drop <= '0;
        end else begin
            stat_kept <= kept_cnt[stat_sel];
            stat_drop <= drop_cnt[stat_sel];
        end
    end
`else
    // Statistics compiled out; core path above is unchanged.
`endif
endmodule

// File: tb/tb_decim_sched.sv
// Scoreboard bench for decim_sched: expectations pushed on accepted handshakes, popped on output.
module tb_decim_sched;
    localparam int DEF = 4;
    localparam int MAXF = 16;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic cfg_load = 1'b0;
    logic [4:0] cfg_factor = '0;
    logic cfg_busy;
    logic [3:0] ch_valid = '0;
    logic [3:0][15:0] ch_data = '0;
    logic [3:0] ch_ready;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic [1:0] out_ch;
`ifdef DECIM_SCHED_STATS_EN
    logic [1:0] stat_sel = '0;
    logic [15:0] stat_kept, stat_drop;
`endif

    decim_sched #(.NUM_CH(4), .WIDTH(16), .MAX_FACTOR(MAXF), .DEFAULT_FACTOR(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_factor (cfg_factor),
        .cfg_busy   (cfg_busy),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch)
`ifdef DECIM_SCHED_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_kept  (stat_kept),
        .stat_drop  (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nxt[4];
    int lim[4];
    int cnt[4];
    int base[4] = '{0, 1000, 2000, -3000};
    int exp_factor = DEF;
    int pend_exp = DEF;
    int n_out = 0;
    logic [3:0] src_on = 4'b1111;
    exp_t sb[$];
    logic [1:0] ch_log[$];
    logic [3:0] smp_ready;
    logic smp_ov, smp_busy;
    logic [15:0] smp_od;
    logic [1:0] smp_oc;

    function automatic int clampf(input int f);
        if (f == 0) return 1;
        if (f > MAXF) return MAXF;
        return f;
    endfunction

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            ch_valid[c] = src_on[c] && (nxt[c] <= lim[c]);
            ch_data[c]  = 16'(base[c] + nxt[c]);
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic [3:0] took;
        drive();
        @(negedge clk);
        smp_ready = ch_ready; smp_ov = out_valid; smp_od = out_data;
        smp_oc = out_ch; smp_busy = cfg_busy;
        took = '0;
        total++;
        if (!$onehot0(ch_ready) || (ch_ready & ~ch_valid) != 4'b0 ||
            ((rst || cfg_busy) && ch_ready != 4'b0)) begin
            bad++;
            $display("FAIL ready_legal ch_ready=%b ch_valid=%b rst=%b busy=%b", ch_ready, ch_valid, rst, cfg_busy);
        end
        if (rst) begin
            sb.delete();
            for (int c = 0; c < 4; c++) cnt[c] = 0;
            exp_factor = DEF;
            pend_exp = DEF;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                ch_log.push_back(out_ch);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra got ch=%0d data=%0d, none expected", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_ch !== e.ch) begin
                        bad++;
                        $display("FAIL sb_data got ch=%0d data=%0d need ch=%0d data=%0d",
                                 out_ch, out_data, e.ch, $signed(e.data));
                    end
                end
            end
            if (cfg_busy) begin
                for (int c = 0; c < 4; c++) cnt[c] = 0;
                exp_factor = pend_exp;
            end
            for (int c = 0; c < 4; c++) begin
                if (ch_ready[c]) begin
                    took[c] = 1'b1;
                    cnt[c]++;
                    if (cnt[c] == exp_factor) begin
                        e.ch = 2'(c);
                        e.data = ch_data[c];
                        sb.push_back(e);
                        cnt[c] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) if (took[c]) nxt[c]++;
    endtask

    task automatic apply_reset();
        rst = 1'b1; src_on = '0; out_ready = 1'b1; en = 1'b1; cfg_load = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin nxt[c] = 1; lim[c] = 100000; end
        n_out = 0;
        ch_log.delete();
    endtask

    task automatic reconf(input int f);
        cfg_factor = 5'(f); cfg_load = 1'b1; pend_exp = clampf(f);
        cycle();
        cfg_load = 1'b0;
        for (int i = 0; i < 30 && cfg_busy; i++) cycle();
        total++;
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL cfg_timeout busy=%b need 0", cfg_busy); end
    endtask

    task automatic drain(input int n);
        src_on = '0; out_ready = 1'b1;
        repeat (n) cycle();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_left pending=%0d need 0", sb.size()); end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin nxt[c] = 1; lim[c] = 100000; end
        src_on = 4'b1111;
        cycle();
        cycle();
        total++;
        if (smp_ov !== 1'b0 || smp_od !== 16'd0 || smp_oc !== 2'd0) begin
            bad++; $display("FAIL reset_out valid=%b data=%0d ch=%0d need 0", smp_ov, smp_od, smp_oc);
        end
        total++;
        if (smp_ready !== 4'b0 || smp_busy !== 1'b0) begin
            bad++; $display("FAIL reset_ctl ready=%b busy=%b need 0", smp_ready, smp_busy);
        end
        rst = 1'b0; src_on = '0;
        cycle();
        total++;
        if (smp_ov !== 1'b0 || smp_busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle valid=%b busy=%b need 0", smp_ov, smp_busy);
        end
    endtask

    task automatic test_single();
        int rdy = 0;
        apply_reset();
        lim[0] = 12; src_on = 4'b0001;
        repeat (12) begin cycle(); if (smp_ready[0]) rdy++; end
        total++;
        if (rdy != 12) begin bad++; $display("FAIL single_ready got=%0d need 12", rdy); end
        drain(4);
        total++;
        if (n_out != 3) begin bad++; $display("FAIL single_count got=%0d need 3", n_out); end
    endtask

    task automatic test_rr();
        int err = 0;
        apply_reset();
        reconf(1);
        n_out = 0; ch_log.delete();
        src_on = 4'b1111;
        repeat (16) cycle();
        src_on = '0;
        cycle();
        total++;
        if (n_out != 16) begin bad++; $display("FAIL rr_count got=%0d need 16", n_out); end
        foreach (ch_log[i]) if (ch_log[i] != 2'(i % 4)) err++;
        total++;
        if (err != 0) begin bad++; $display("FAIL rr_order out-of-order=%0d need 0", err); end
        drain(2);
    endtask

    task automatic test_back_pressure();
        int rdy = 0;
        apply_reset();
        reconf(2);
        out_ready = 1'b0; src_on = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (smp_ready != 4'b0) rdy++;
            if (i >= 3) begin
                total++;
                if (smp_ov !== 1'b1 || smp_od !== 16'd2 || smp_oc !== 2'd0 || smp_ready !== 4'b0) begin
                    bad++;
                    $display("FAIL bp_hold valid=%b data=%0d ch=%0d ready=%b need 1/2/0/0",
                             smp_ov, smp_od, smp_oc, smp_ready);
                end
            end
        end
        total++;
        if (rdy != 3) begin bad++; $display("FAIL bp_consumed got=%0d need 3", rdy); end
        out_ready = 1'b1;
        repeat (6) cycle();
        drain(4);
    endtask

    task automatic test_reconfig();
        apply_reset();
        src_on = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 40 && !smp_ov; i++) cycle();
        total++;
        if (smp_ov !== 1'b1) begin bad++; $display("FAIL rc_fill valid=%b need 1", smp_ov); end
        cfg_factor = 5'd2; cfg_load = 1'b1; pend_exp = 2;
        cycle();
        cfg_load = 1'b0;
        repeat (3) begin
            cycle();
            total++;
            if (smp_busy !== 1'b1) begin bad++; $display("FAIL rc_busy got=%b need 1", smp_busy); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && cfg_busy; i++) cycle();
        total++;
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL rc_release busy=%b need 0", cfg_busy); end
        repeat (12) cycle();
        drain(4);
    endtask

    task automatic test_clamp();
        apply_reset();
        reconf(0);
        n_out = 0; lim[2] = 6; src_on = 4'b0100;
        repeat (8) cycle();
        drain(3);
        total++;
        if (n_out != 6) begin bad++; $display("FAIL clamp_lo got=%0d need 6", n_out); end
        reconf(MAXF + 5);
        n_out = 0; lim[2] = nxt[2] + 31; src_on = 4'b0100;
        repeat (34) cycle();
        drain(3);
        total++;
        if (n_out != 2) begin bad++; $display("FAIL clamp_hi got=%0d need 2", n_out); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        src_on = 4'b0001; out_ready = 1'b0;
        for (int i = 0; i < 20 && !smp_ov; i++) cycle();
        src_on = '0;
        cfg_factor = 5'd3; cfg_load = 1'b1; pend_exp = 3;
        cycle();
        cfg_load = 1'b0;
        cycle();
        total++;
        if (smp_busy !== 1'b1 || smp_ov !== 1'b1) begin
            bad++; $display("FAIL rm_pre busy=%b valid=%b need 1/1", smp_busy, smp_ov);
        end
        rst = 1'b1;
        cycle();
        cycle();
        total++;
        if (smp_ov !== 1'b0 || smp_od !== 16'd0 || smp_oc !== 2'd0 || smp_busy !== 1'b0) begin
            bad++; $display("FAIL rm_clear valid=%b data=%0d ch=%0d busy=%b need 0",
                            smp_ov, smp_od, smp_oc, smp_busy);
        end
        rst = 1'b0; n_out = 0; out_ready = 1'b1; src_on = 4'b1111;
        cycle();
        total++;
        if (smp_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr ready=%b need 0001", smp_ready); end
        repeat (15) cycle();
        drain(3);
        total++;
        if (n_out != 4) begin bad++; $display("FAIL rm_factor outputs=%0d need 4", n_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_back_pressure();
        test_reconfig();
        test_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
